// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the sequencer state encoding and the default operand and chunk
// widths for the multiword add/subtract controller.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } addseq_state_t;

   localparam int ADD_N_DEFAULT = 8;
   localparam int ADD_W_DEFAULT = 2;

endpackage

// File: rtl/adder.sv
// Narrow W-bit ripple adder shared by the multiword sequencer.
// Ports:
//   a, b  : W-bit addends
//   cin   : carry in
//   s     : W-bit sum
//   cout  : carry out of the top bit
module adder #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   // Zero-extend everything to W+1 bits so the carry lands in the top bit.
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_ctrl.sv
// Multiword add/subtract sequencer.
// Performs an N-bit add or subtract by reusing one W-bit adder over N/W
// cycles, least-significant chunk first, chaining the carry through a flop.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   start         : request, taken only in IDLE or DONE
//   op_sub        : 0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b, cin     : operands, latched when a request is accepted
//   busy          : high while the chunks are being processed
//   done          : one-cycle completion pulse
//   s, cout, ovf  : registered result, final carry and signed overflow
module multiword_add_ctrl
   import alu_pkg::*;
#(
   parameter int N = ADD_N_DEFAULT,
   parameter int W = ADD_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op_sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf
);

   localparam int K    = N / W;
   localparam int IDXW = $clog2(K);

   addseq_state_t state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [N-1:0]    s_q, s_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [W-1:0]    chunk_a;
   logic [W-1:0]    chunk_b;
   logic [W-1:0]    chunk_s;
   logic            chunk_c;
   logic            accept;
   logic            last_chunk;

   // The single shared adder always looks at the chunk selected by idx.
   assign chunk_a = a_q[idx_q*W +: W];
   assign chunk_b = b_q[idx_q*W +: W];

   adder #(.W(W)) u_adder (
      .a    (chunk_a),
      .b    (chunk_b),
      .cin  (carry_q),
      .s    (chunk_s),
      .cout (chunk_c)
   );

   assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_chunk = (idx_q == IDXW'(K - 1));

   // Next-state logic: process one chunk per RUN cycle; an accepted start
   // overrides whatever IDLE or DONE would otherwise do, which gives the
   // back-to-back path out of DONE for free.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         RUN: begin
            s_d[idx_q*W +: W] = chunk_s;
            carry_d           = chunk_c;
            idx_d             = idx_q + 1'b1;
            if (last_chunk) begin
               // The top chunk's sum MSB is the result sign bit; B here is
               // already inverted for subtract, so one rule covers both ops.
               cout_d  = chunk_c;
               ovf_d   = (a_q[N-1] == b_q[N-1]) && (chunk_s[W-1] != a_q[N-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
         end
      endcase

      if (accept) begin
         a_d     = a;
         b_d     = op_sub ? ~b : b;
         carry_d = op_sub ? 1'b1 : cin;
         idx_d   = '0;
         s_d     = '0;
         cout_d  = 1'b0;
         ovf_d   = 1'b0;
         state_d = RUN;
      end
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Testbench for multiword_add_ctrl: directed cases plus randomized
// operations, checked through a result queue and an independent monitor.
module tb_multiword_add_ctrl;
   import alu_pkg::*;

   localparam int N = ADD_N_DEFAULT;
   localparam int W = ADD_W_DEFAULT;
   localparam int K = N / W;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] s;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic [N-1:0] s;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t expQ[$];
   exp_t monEntry;
   int   checks      = 0;
   int   errors      = 0;
   int   cycleCount  = 0;
   int   doneCount   = 0;
   int   acceptCount = 0;
   int   abortCount  = 0;
   logic prevDone    = 1'b0;

   multiword_add_ctrl #(.N(N), .W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .s      (s),
      .cout   (cout),
      .ovf    (ovf)
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the whole operands.
   function automatic exp_t model(input logic sub, input logic [N-1:0] av,
                                  input logic [N-1:0] bv, input logic ci);
      exp_t e;
      int ua, ub, sa, sb, r, sr;
      ua = int'(av);
      ub = int'(bv);
      sa = int'($signed(av));
      sb = int'($signed(bv));
      if (sub) begin
         r      = ua - ub;
         sr     = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         r      = ua + ub + int'(ci);
         sr     = sa + sb + int'(ci);
         e.cout = (r >= (1 << N));
      end
      e.s   = N'(r & ((1 << N) - 1));
      e.ovf = (sr > ((1 << (N - 1)) - 1)) || (sr < -(1 << (N - 1)));
      e.cyc = 0;
      return e;
   endfunction

   // Wait for a negedge where the DUT sits in DONE (wantDone) or in IDLE.
   task automatic waitAccepting(input bit wantDone);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wantDone ? (done === 1'b1) : (busy === 1'b0 && done === 1'b0)) return;
      end
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout actual=expired required=%s", wantDone ? "done" : "idle");
   endtask

   task automatic applyStimulus(input logic sub, input logic [N-1:0] av,
                                input logic [N-1:0] bv, input logic ci, input bit backToBack);
      exp_t e;
      waitAccepting(backToBack);
      op_sub = sub;
      a      = av;
      b      = bv;
      cin    = ci;
      start  = 1'b1;
      e      = model(sub, av, bv, ci);
      @(posedge clk);
      #1;
      start = 1'b0;
      e.cyc = cycleCount;
      expQ.push_back(e);
      acceptCount++;
      checkOutput("busy_after_accept", busy, 1);
      checkOutput("done_after_accept", done, 0);
      checkOutput("s_cleared_on_accept", s, 0);
      checkOutput("cout_cleared_on_accept", cout, 0);
      checkOutput("ovf_cleared_on_accept", ovf, 0);
   endtask

   task automatic runAndExpect(input logic sub, input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic ci, input logic [N-1:0] es, input logic ec, input logic eo);
      applyStimulus(sub, av, bv, ci, 1'b0);
      waitAccepting(1'b0);
      checkOutput("directed_s", s, es);
      checkOutput("directed_cout", cout, ec);
      checkOutput("directed_ovf", ovf, eo);
   endtask

   // Monitor: every done pulse pops one expected result and checks it.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (done === 1'b1) begin
            doneCount++;
            checkOutput("busy_done_exclusive", busy, 0);
            checkOutput("done_single_cycle", prevDone, 0);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done actual=done required=none s=0x%0h", s);
            end else begin
               monEntry = expQ.pop_front();
               checkOutput("result_s", s, monEntry.s);
               checkOutput("result_cout", cout, monEntry.cout);
               checkOutput("result_ovf", ovf, monEntry.ovf);
               checkOutput("latency", cycleCount, monEntry.cyc + K);
            end
         end
         prevDone = done;
      end else begin
         prevDone = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneBefore;
      rst    = 1'b1;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      cin    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_s", s, 0);
      checkOutput("reset_cout", cout, 0);
      checkOutput("reset_ovf", ovf, 0);
      rst = 1'b0;

      $display("[TB] directed add/sub cases");
      runAndExpect(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      runAndExpect(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      runAndExpect(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
      runAndExpect(1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);

      $display("[TB] start and operand changes during RUN");
      doneBefore = doneCount;
      applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; op_sub = 1'b1; start = 1'b1;
      @(negedge clk);
      a = 8'h77; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      waitAccepting(1'b0);
      checkOutput("ignore_s", s, 8'h46);
      checkOutput("ignore_done_count", doneCount - doneBefore, 1);

      $display("[TB] reset in the middle of RUN");
      doneBefore = doneCount;
      applyStimulus(1'b0, 8'hF0, 8'h0F, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      expQ.delete();
      abortCount++;
      #1;
      checkOutput("midrun_reset_busy", busy, 0);
      checkOutput("midrun_reset_done", done, 0);
      checkOutput("midrun_reset_s", s, 0);
      checkOutput("midrun_reset_cout", cout, 0);
      checkOutput("midrun_reset_ovf", ovf, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("aborted_no_done", doneCount - doneBefore, 0);
      runAndExpect(1'b0, 8'h21, 8'h10, 1'b1, 8'h32, 1'b0, 1'b0);

      $display("[TB] back-to-back start from DONE");
      applyStimulus(1'b0, 8'h11, 8'h22, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
      waitAccepting(1'b0);
      checkOutput("b2b_s", s, 8'h02);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         logic         rSub;
         logic         rCin;
         logic [N-1:0] rA;
         logic [N-1:0] rB;
         bit           rB2b;
         rSub = 1'($urandom_range(0, 1));
         rCin = 1'($urandom_range(0, 1));
         rA   = N'($urandom);
         rB   = N'($urandom);
         rB2b = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         applyStimulus(rSub, rA, rB, rCin, rB2b);
      end
      waitAccepting(1'b0);
      repeat (2) @(negedge clk);

      checkOutput("queue_empty", expQ.size(), 0);
      checkOutput("total_done_count", doneCount, acceptCount - abortCount);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiword_add_ctrl.md
# multiword_add_ctrl

Sequencer that performs N-bit add/subtract by time-multiplexing one narrow W-bit `adder` instance over N/W cycles, least-significant chunk first, with the carry chained through a register. It sits in the ALU between the operand registers and the result bus. It trades latency for adder area, and exposes a start/busy/done handshake to the ALU control.

## Interface
Parameters:
- `N`, 8, total operand width; must be a multiple of `W`, with N/W ≥ 2
- `W`, 2, chunk width; width of the shared `adder` instance

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only when the block accepts (IDLE or DONE)
- `op_sub`  in  1  0 = a+b+cin; 1 = a−b (computed as a+~b+1, `cin` ignored)
- `a`  in  N  operand A, latched on accepted start
- `b`  in  N  operand B, latched on accepted start
- `cin`  in  1  carry-in for add, latched on accepted start
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse in DONE
- `s`  out  N  result; held from DONE until the next accepted start
- `cout`  out  1  final carry; for subtract, 1 = no borrow
- `ovf`  out  1  signed two's-complement overflow of the full N-bit operation

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1: latch `a`, `b` (inverted if `op_sub`), carry register ← (`op_sub` ? 1 : `cin`), idx ← 0, clear `s`, go to RUN.
- RUN: adder inputs are chunk[idx] of the latched A and B plus the carry register.
  - Write the adder sum to `s[idx*W +: W]` and the adder carry to the carry register; idx++.
  - When idx = N/W−1 is processed: `cout` ← adder carry, compute `ovf`, go to DONE.
- `ovf` = (A[N−1] == Beff[N−1]) && (s[N−1] != A[N−1]), where Beff is the possibly-inverted B.
- DONE: done=1. If start=1, accept it exactly as IDLE does and go to RUN (back-to-back); otherwise go to IDLE.
- `start` during RUN is ignored. Operand changes after acceptance have no effect.
- `s`, `cout` and `ovf` are registered outputs. They are stable in DONE and in IDLE until the next accept; on accept they clear to 0.
- Reset, including mid-RUN: state IDLE, idx 0, `busy` 0, `done` 0, `s` 0, `cout` 0, `ovf` 0, carry register 0. An aborted operation never produces `done`.

## Timing
- K = N/W. Start sampled at edge E0.
- RUN occupies cycles E0..E(K); chunk i is written at edge E(i+1).
- DONE is entered at E(K); `done`=1 for the single cycle between E(K) and E(K+1).
- Latency from accepted start to `done` is K cycles (4 for the defaults). Throughput is one operation per K+1 cycles idle-to-idle, or one per K cycles back-to-back.
- `busy` is 1 exactly in RUN; `busy` and `done` are never high together.
- The adder path is combinational within one cycle; there are no multicycle paths.

## Structure
- Shared package `alu_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} addseq_state_t`
  - localparams for the default N and W.
- One sub-module: the existing `adder #(W)` (ports a, b, cin, s, cout), instantiated exactly once.
- idx width is $clog2(N/W).

## Test plan
Defaults N=8, W=2:
- Add 0x5A+0x3C, cin=0 -> `done` 4 cycles after start; s=0x96, cout=0, ovf=1.
- Add 0xFF+0x00, cin=1 -> s=0x00, cout=1, ovf=0 (carry ripples through all 4 chunks).
- Sub 0x80−0x01 -> s=0x7F, cout=1, ovf=1. Sub 0x00−0x01 with cin=0 driven -> s=0xFF, cout=0, ovf=0.
- Change `a` and `b` and pulse `start` during RUN -> ignored; result reflects the originally latched operands; exactly one `done`.
- Assert `rst` at the second RUN cycle -> all outputs 0 immediately, no `done`. A new start afterwards completes correctly.
- Hold `start`=1 in the DONE cycle with new operands 0x01+0x01 -> `busy` on the next cycle; `done` 4 cycles later with s=0x02. The previous `done` pulse lasts exactly 1 cycle.
